// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: Avalon-MM interrupt controller.
// Captures NUM_SRC request lines (level or rising edge) into a pending
// register, masks them, priority-encodes the lowest active source and
// drives one registered irq_out.
// Optional build macro: IRQC_SYNC_EN adds a 2-flop synchronizer on irq_in.
//
// Bus handshake: the slave has no wait states. A write commits on the
// clock edge where chipselect=1 and write_n=0, to the register selected
// by address. readdata is registered: it shows the register selected by
// address on the previous edge, independent of chipselect. Reads have no
// side effects.
module irq_pending_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq_out
);

  // Bits that correspond to implemented sources; all others stay 0.
  localparam logic [15:0] IMPL = (NUM_SRC >= 16) ? 16'hFFFF
                                 : 16'((32'd1 << NUM_SRC) - 32'd1);

  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_EDGE    = 3'd2;
  localparam logic [2:0] A_ACTIVE  = 3'd3;
  localparam logic [2:0] A_RAW     = 3'd4;
  localparam logic [2:0] A_SWSET   = 3'd5;

  logic [NUM_SRC-1:0] src_s;
  logic [15:0]        src_w;
  logic [15:0]        prev;
  logic [15:0]        pending;
  logic [15:0]        mask;
  logic [15:0]        edge_mode;
  logic [15:0]        set_vec;
  logic [15:0]        clr_vec;
  logic [15:0]        pending_nxt;
  logic [15:0]        act;
  logic [3:0]         act_id;
  logic [15:0]        active_word;
  logic [15:0]        rd_mux;
  logic               wr_en;
  logic               pending_wr;
  logic               mask_wr;
  logic               edge_wr;
  logic               swset_wr;

`ifdef IRQC_SYNC_EN
  logic [NUM_SRC-1:0] sync_a;
  logic [NUM_SRC-1:0] sync_b;

  // Two-flop synchronizer for sources from other clock domains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= irq_in;
      sync_b <= sync_a;
    end
  end

  assign src_s = sync_b;
`else
  assign src_s = irq_in;
`endif

  // Widen sampled sources to the 16-bit register layout.
  always_comb begin
    src_w = '0;
    src_w[NUM_SRC-1:0] = src_s;
  end

  assign wr_en      = chipselect & ~write_n;
  assign pending_wr = wr_en & (address == A_PENDING);
  assign mask_wr    = wr_en & (address == A_MASK);
  assign edge_wr    = wr_en & (address == A_EDGE);
  assign swset_wr   = wr_en & (address == A_SWSET);

  // Set and clear terms; a set in the same cycle as a clear wins.
  always_comb begin
    set_vec     = ((edge_mode & src_w & ~prev) | (~edge_mode & src_w)
                   | (swset_wr ? writedata : 16'h0000)) & IMPL;
    clr_vec     = pending_wr ? writedata : 16'h0000;
    pending_nxt = (set_vec | (pending & ~clr_vec)) & IMPL;
  end

  // Priority encode: lowest-numbered active source has highest priority.
  always_comb begin
    act    = pending & mask;
    act_id = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (act[i]) act_id = 4'(i);
    end
    active_word = (|act) ? {1'b1, 11'b0, act_id} : 16'h0000;
  end

  // Read mux; unmapped and write-only addresses read 0.
  always_comb begin
    rd_mux = 16'h0000;
    case (address)
      A_PENDING: rd_mux = pending;
      A_MASK:    rd_mux = mask;
      A_EDGE:    rd_mux = edge_mode;
      A_ACTIVE:  rd_mux = active_word;
      A_RAW:     rd_mux = src_w;
      default:   rd_mux = 16'h0000;
    endcase
  end

  // Register file, edge history, registered read data and irq output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev      <= '0;
      pending   <= '0;
      mask      <= '0;
      edge_mode <= '0;
      readdata  <= '0;
      irq_out   <= 1'b0;
    end else begin
      prev     <= src_w;
      pending  <= pending_nxt;
      readdata <= rd_mux;
      irq_out  <= |act;
      if (mask_wr) mask <= writedata & IMPL;
      if (edge_wr) edge_mode <= writedata & IMPL;
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Testbench for irq_pending_ctrl: directed vectors, scoreboard queue,
// decoupled monitor.
module tb_irq_pending_ctrl;

`ifdef IRQC_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  localparam logic [2:0] A_PENDING = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_EDGE    = 3'd2;
  localparam logic [2:0] A_ACTIVE  = 3'd3;
  localparam logic [2:0] A_RAW     = 3'd4;
  localparam logic [2:0] A_SWSET   = 3'd5;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic [7:0]  irq_in = '0;
  logic        irq_out;

  always #5 clk = ~clk;

  irq_pending_ctrl #(.NUM_SRC(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq_out    (irq_out)
  );

  // scoreboard
  logic [15:0] exp_q[$];
  bit          kind_q[$];   // 0 = readdata, 1 = irq_out
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        smp_req = 1'b0;
  logic        mon_vld = 1'b0;

  // driver tasks: each starts and ends at a falling edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // Expect the register at address a as it stands now.
  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string n);
    address = a;
    exp_q.push_back(e);
    kind_q.push_back(1'b0);
    name_q.push_back(n);
    smp_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    smp_req = 1'b0;
  endtask

  // Expect irq_out after the next rising edge.
  task automatic chk_irq(input logic e, input string n);
    exp_q.push_back({15'b0, e});
    kind_q.push_back(1'b1);
    name_q.push_back(n);
    smp_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    smp_req = 1'b0;
  endtask

  // monitor: output presented one edge after the request
  always @(posedge clk) mon_vld <= smp_req;

  always @(negedge clk) begin
    if (mon_vld) begin
      logic [15:0] e;
      logic [15:0] got;
      bit          k;
      string       n;
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard_underflow: no expected entry");
      end else begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        n = name_q.pop_front();
        got = k ? {15'b0, irq_out} : readdata;
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s: got 0x%04h expected 0x%04h", n, got, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // directed stimulus
  initial begin
    @(negedge clk);
    @(negedge clk);
    // reset state
    rd(A_PENDING, 16'h0000, "reset_pending");
    chk_irq(1'b0, "reset_irq");
    reset_n = 1'b1;
    rd(A_MASK, 16'h0000, "reset_mask");
    rd(A_EDGE, 16'h0000, "reset_edge");

    // level capture and set latency
    wr(A_MASK, 16'h0001);
    wr(A_EDGE, 16'h0000);
    irq_in = 8'h01;
    for (int k = 0; k <= SL + 1; k++) chk_irq(k == SL + 1, "lvl_latency");
    rd(A_PENDING, 16'h0001, "lvl_pending");
    rd(A_ACTIVE,  16'h8000, "lvl_active");
    wr(A_PENDING, 16'h0001);
    rd(A_PENDING, 16'h0001, "lvl_w1c_resets");
    irq_in = 8'h00;
    tick(SL);
    wr(A_PENDING, 16'h0001);
    rd(A_PENDING, 16'h0000, "lvl_cleared");
    chk_irq(1'b0, "lvl_irq_low");

    // edge capture of a one-cycle pulse
    wr(A_EDGE, 16'h0004);
    wr(A_MASK, 16'h0004);
    irq_in = 8'h04;
    tick(1);
    irq_in = 8'h00;
    tick(SL);
    rd(A_PENDING, 16'h0004, "edge_latched");
    chk_irq(1'b1, "edge_irq");
    wr(A_PENDING, 16'h0004);
    rd(A_PENDING, 16'h0000, "edge_cleared");
    chk_irq(1'b0, "edge_irq_low");

    // priority encoding under masks
    wr(A_EDGE, 16'h0000);
    wr(A_MASK, 16'h00FF);
    irq_in = 8'hA4;
    tick(SL + 1);
    rd(A_ACTIVE,  16'h8002, "prio_all");
    rd(A_RAW,     16'h00A4, "prio_raw");
    wr(A_MASK, 16'h00A0);
    rd(A_ACTIVE,  16'h8005, "prio_a0");
    wr(A_MASK, 16'h0000);
    rd(A_ACTIVE,  16'h0000, "prio_none");
    chk_irq(1'b0, "prio_irq_low");
    rd(A_PENDING, 16'h00A4, "prio_pending_kept");
    irq_in = 8'h00;
    tick(SL + 1);
    wr(A_PENDING, 16'hFFFF);
    rd(A_PENDING, 16'h0000, "prio_cleanup");

    // set/clear collision in edge mode
    wr(A_EDGE, 16'h0008);
    wr(A_MASK, 16'h0008);
    wr(A_SWSET, 16'h0008);
    irq_in = 8'h08;
    tick(SL);
    wr(A_PENDING, 16'h0008);
    rd(A_PENDING, 16'h0008, "collision_set_wins");
    wr(A_PENDING, 16'h0008);
    rd(A_PENDING, 16'h0000, "edge_no_reset_while_high");
    irq_in = 8'h00;
    tick(SL + 1);

    // software set and bounds
    wr(A_SWSET, 16'hFFFF);
    rd(A_PENDING, 16'h00FF, "swset_bounds");
    rd(A_SWSET,   16'h0000, "swset_reads0");
    rd(3'd6,      16'h0000, "addr6");
    rd(3'd7,      16'h0000, "addr7");
    wr(A_MASK, 16'hFFFF);
    rd(A_MASK,    16'h00FF, "mask_bounds");
    rd(A_ACTIVE,  16'h8000, "active_bit0");
    chk_irq(1'b1, "irq_before_reset");
    tick(1);

    // asynchronous reset mid-cycle
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (irq_out !== 1'b0) begin
      errors++;
      $display("FAIL async_irq: got %0b expected 0", irq_out);
    end
    checks++;
    if (readdata !== 16'h0000) begin
      errors++;
      $display("FAIL async_readdata: got 0x%04h expected 0x0000", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    rd(A_PENDING, 16'h0000, "post_reset_pending");
    rd(A_MASK,    16'h0000, "post_reset_mask");
    rd(A_EDGE,    16'h0000, "post_reset_edge");
    chk_irq(1'b0, "post_reset_irq");

    tick(2);
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover: %0d entries remain", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
